// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer (start, MSB-first data, even parity, stop) with FWFT receive FIFO.
// Optional build macro RX_ERROR_STORE_EN: parity/frame-errored (non-break) frames are also stored.
module uart_rx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Read,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Empty,
    output logic                 Rx_Full,
    output logic                 Rx_Busy,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 commit;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 all_zero;
    logic                 stop_bad;
    logic                 brk_now, par_now, frm_now;
    logic                 good, store_req, push, pop;
    logic [AW:0]          wptr, rptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    // Error flags are evaluated against the last stop bit currently on the line.
    assign brk_now = all_zero & ~Rx;
    assign par_now = (par_bit != ^shreg) & ~brk_now;
    assign frm_now = (stop_bad | ~Rx) & ~brk_now;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (!Rx) begin
                    state_nxt = DATA;
                    cnt_nxt   = CW'(DATA_BITS - 1);
                end
            end
            DATA: begin
                if (cnt == '0) state_nxt = PARITY;
                else           cnt_nxt   = cnt - 1'b1;
            end
            PARITY: begin
                state_nxt = STOP;
                cnt_nxt   = CW'(STOP_BITS - 1);
            end
            STOP: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = brk_now ? BRK_WAIT : IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            BRK_WAIT: begin
                if (Rx) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            shreg    <= '0;
            par_bit  <= 1'b0;
            all_zero <= 1'b0;
            stop_bad <= 1'b0;
            Rx_Error <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    all_zero <= 1'b1;
                    stop_bad <= 1'b0;
                end
                DATA: begin
                    shreg    <= {shreg[DATA_BITS-2:0], Rx};
                    all_zero <= all_zero & ~Rx;
                end
                PARITY: begin
                    par_bit  <= Rx;
                    all_zero <= all_zero & ~Rx;
                end
                STOP: begin
                    all_zero <= all_zero & ~Rx;
                    if (!Rx) stop_bad <= 1'b1;
                end
                default: ;
            endcase
            if (commit) Rx_Error <= {frm_now, par_now, brk_now};
        end
    end

    assign good = commit & ~brk_now & ~par_now & ~frm_now;
`ifdef RX_ERROR_STORE_EN
    assign store_req = commit & ~brk_now;
`else
    assign store_req = good;
`endif

    // A pop on the same edge frees the slot the incoming frame needs.
    assign pop  = Read & ~Rx_Empty;
    assign push = store_req & (~Rx_Full | pop);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr        <= '0;
            rptr        <= '0;
            Rx_Overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (good && Rx_Full && !pop) Rx_Overflow <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wptr[AW-1:0]] <= shreg;
    end

    assign Rx_Empty = (wptr == rptr);
    assign Rx_Full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign Rx_Data  = Rx_Empty ? '0 : mem[rptr[AW-1:0]];
    assign Rx_Busy  = (state != IDLE);

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Receive half of the UART serial link. Deserialises frames arriving on Rx and checks parity, stop bits and break.
- Error-free data goes into an internal receive FIFO. The host drains the FIFO with a pop strobe.
- Frame format on the wire: start bit (0), DATA_BITS data bits MSB first, one even-parity bit (XOR of the data bits), then STOP_BITS stop bits (1).
- One bit occupies exactly one Clk period. Clk is the bit-rate clock.

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of two, minimum 2.

Ports:
- Clk  input  1  bit-rate clock; every input is sampled on its rising edge.
- Rst  input  1  synchronous reset, active-high.
- Rx  input  1  serial line; idles high.
- Read  input  1  pop strobe; removes the FIFO head on the Clk edge when Rx_Empty=0.
- Rx_Data  output  DATA_BITS  FIFO head (first-word fall-through); don't-care when empty.
- Rx_Empty  output  1  FIFO holds no entries.
- Rx_Full  output  1  FIFO holds FIFO_DEPTH entries.
- Rx_Busy  output  1  high while a frame is in progress (state is not IDLE).
- Rx_Error  output  3  [0] break, [1] parity, [2] frame; result of the last completed frame.
- Rx_Overflow  output  1  sticky; a good frame was dropped because the FIFO was full.

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - State goes to IDLE; bit counter and FIFO pointers clear.
  - Outputs: Rx_Empty=1, Rx_Full=0, Rx_Busy=0, Rx_Error=3'b000, Rx_Overflow=0, Rx_Data=0.
  - Rst wins over everything. A partial frame is discarded. Reset mid-frame leaves the FIFO empty.
- State machine (one transition per Clk edge):
  - IDLE: Rx=0 sampled -> DATA, counter=DATA_BITS-1. Rx=1 -> stay in IDLE.
  - DATA: shift Rx into the LSB of the shift register. Counter 0 -> PARITY, else decrement.
  - PARITY: capture the parity bit, go to STOP with counter=STOP_BITS-1.
  - STOP: sample stop bits. On the last stop bit -> commit, then go to IDLE; if the frame was a break, go to BRK_WAIT instead.
  - BRK_WAIT: stay until Rx=1 is sampled, then go to IDLE. Rx_Busy=1 in this state.
- Back-to-back frames: a start bit on the edge immediately after the last stop bit is accepted; no idle gap is required.
- Commit, on the edge that samples the last stop bit:
  - break = all TX_BITS samples were 0, where TX_BITS = DATA_BITS+STOP_BITS+2.
  - parity error = parity bit != XOR of data bits, and not break.
  - frame error = any stop bit 0, and not break.
  - Rx_Error is loaded with {frame, parity, break}. It holds until the next commit or reset. It is readable on the edge after commit.
- FIFO push:
  - Only when all three error bits are 0 (see Optional Feature).
  - Full at commit: the data is dropped and Rx_Overflow is set. Rx_Overflow clears only on reset.
  - Push latency: Rx_Empty falls and Rx_Data is valid immediately after the commit edge.
- FIFO pop:
  - Read with Rx_Empty=0 advances the read pointer.
  - Read with Rx_Empty=1 is ignored; no state change, no error.
- Simultaneous push and pop:
  - Both are performed; the count is unchanged.
  - When full, the pop frees a slot, so the push is accepted and Rx_Overflow stays 0.
  - When empty, the push happens and the Read is ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. The MSB distinguishes full from empty.

Optional Feature:
- Macro: RX_ERROR_STORE_EN.
- Defined: frames with a parity or frame error, but not break, are also pushed into the FIFO. Rx_Error still reports the error. Break frames are never pushed.
- Undefined: only frames with Rx_Error=000 are pushed; errored frames are discarded.
- Rx_Error and Rx_Overflow behave the same in both builds.

Test Plan:
- Frame 0xA5, parity 0, stop 1 -> after the last stop edge: Rx_Empty=0, Rx_Data=8'hA5, Rx_Error=000, Rx_Busy=0.
- Eight back-to-back frames 0..7 with no gaps, then Read eight times -> data 0..7 in order, Rx_Full=1 after the eighth frame, Rx_Empty=1 after the last pop.
- Ninth frame 0x55 while full -> Rx_Overflow=1, head still 0x00. Repeat with Read=1 on the commit edge -> Rx_Overflow=0 and 0x55 stored last.
- Frame 0xAA with parity inverted -> Rx_Error=010, FIFO stays empty. With RX_ERROR_STORE_EN: Rx_Data=0xAA, Rx_Error=010.
- Frame 0xAA with stop=0 -> Rx_Error=100. All-zero frame with Rx held low 3 more cycles -> Rx_Error=001, Rx_Busy=1 until Rx returns high, no push in either build.
- Rst=1 during the 4th data bit of a frame -> Rx_Busy=0, Rx_Empty=1, Rx_Error=000 next cycle. A following clean frame 0x3C is received correctly.
